dist_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `dist` decoder among four requesters. It grants one requester at a time and drives that requester's 4-bit code `{A,B,C,D}` onto the decoder inputs. It holds the code for a programmable settle time, then registers the decoder's 5-bit output and returns it on a valid/ready response channel tagged with the requester ID. It sits between client logic and a single `dist` instance, which it fully owns.

---
 rtl/dist_arbiter.sv | 116 +++++++++++
 tb/tb_dist_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_arbiter.sv
// Round-robin arbiter that time-shares one external dist decoder among four
// requesters and returns each decoded result on a valid/ready channel.
module dist_arbiter #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] code,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic [3:0]  dec_abcd,
    input  logic [4:0]  dec_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_id,
    output logic [4:0]  rsp_data
);

    localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
    localparam logic [3:0]  CNT_LOAD   = 4'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  gnt_q;
    logic        busy_q;
    logic [3:0]  dec_q;
    logic        valid_q;
    logic [1:0]  id_q;
    logic [4:0]  data_q;
    logic [1:0]  last_q;
    logic [3:0]  cnt_q;

    logic        win_vld_d;
    logic [1:0]  win_id_d;
    logic [1:0]  scan_idx;
    logic [3:0]  win_code_d;

    // Scan upward from the slot after the last-served requester, wrapping mod 4.
    always_comb begin
        win_vld_d = 1'b0;
        win_id_d  = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            scan_idx = last_q + 2'(i + 1);
            if (!win_vld_d && req[scan_idx]) begin
                win_vld_d = 1'b1;
                win_id_d  = scan_idx;
            end
        end
    end

    assign win_code_d = code[{win_id_d, 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            dec_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        gnt_q   <= 4'b0001 << win_id_d;
                        id_q    <= win_id_d;
                        dec_q   <= win_code_d;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        data_q  <= dec_b;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        gnt_q   <= '0;
                        dec_q   <= '0;
                        busy_q  <= 1'b0;
                        last_q  <= id_q;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign dec_abcd  = dec_q;
    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

endmodule

// File: tb/tb_dist_arbiter.sv
// Self-checking bench for dist_arbiter: table-driven cycle vectors, a response
// scoreboard, and hand-written sequences for backpressure, reset and fairness.
module tb_dist_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req_a = '0;
    logic [15:0] code_a = '0;
    logic [3:0]  gnt_a;
    logic        busy_a;
    logic [3:0]  dec_abcd_a;
    logic [4:0]  dec_b_a;
    logic        rsp_valid_a;
    logic        rsp_ready_a = 1'b1;
    logic [1:0]  rsp_id_a;
    logic [4:0]  rsp_data_a;

    logic [3:0]  req_b = '0;
    logic [15:0] code_b = '0;
    logic [3:0]  gnt_b;
    logic        busy_b;
    logic [3:0]  dec_abcd_b;
    logic [4:0]  dec_b_b;
    logic        rsp_valid_b;
    logic        rsp_ready_b = 1'b1;
    logic [1:0]  rsp_id_b;
    logic [4:0]  rsp_data_b;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [4:0] data;
    } rsp_t;

    rsp_t sb_q[$];
    rsp_t mon_e;

    typedef struct {
        logic        rst_before;
        logic [3:0]  req;
        logic [15:0] code;
        logic        rdy;
        logic        push;
        logic [1:0]  sb_id;
        logic [4:0]  sb_data;
        logic [3:0]  gnt;
        logic        busy;
        logic [3:0]  dec;
        logic        vld;
        logic [1:0]  id;
        logic [4:0]  data;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    // Behavioural stand-in for the external dist decoder.
    function automatic logic [4:0] dist_f(input logic [3:0] x);
        logic a, b, c, d;
        {a, b, c, d} = x;
        return {(a & b) | (b & c), a & ~b & ~c, (~a & b) | (b & c),
                (a & b & ~c) | (~a & c), d};
    endfunction

    assign dec_b_a = dist_f(dec_abcd_a);
    assign dec_b_b = dist_f(dec_abcd_b);

    dist_arbiter #(.SETTLE(1)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .req       (req_a),
        .code      (code_a),
        .gnt       (gnt_a),
        .busy      (busy_a),
        .dec_abcd  (dec_abcd_a),
        .dec_b     (dec_b_a),
        .rsp_valid (rsp_valid_a),
        .rsp_ready (rsp_ready_a),
        .rsp_id    (rsp_id_a),
        .rsp_data  (rsp_data_a)
    );

    dist_arbiter #(.SETTLE(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req_b),
        .code      (code_b),
        .gnt       (gnt_b),
        .busy      (busy_b),
        .dec_abcd  (dec_abcd_b),
        .dec_b     (dec_b_b),
        .rsp_valid (rsp_valid_b),
        .rsp_ready (rsp_ready_b),
        .rsp_id    (rsp_id_b),
        .rsp_data  (rsp_data_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rb, input logic [3:0] rq, input logic [15:0] cd,
                                input logic rdy, input logic ps, input logic [1:0] sid,
                                input logic [4:0] sdat, input logic [3:0] g, input logic bz,
                                input logic [3:0] dc, input logic v, input logic [1:0] id,
                                input logic [4:0] dat);
        vec_t r;
        r.rst_before = rb; r.req = rq; r.code = cd; r.rdy = rdy;
        r.push = ps; r.sb_id = sid; r.sb_data = sdat;
        r.gnt = g; r.busy = bz; r.dec = dc; r.vld = v; r.id = id; r.data = dat;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_a = '0; code_a = '0; rsp_ready_a = 1'b1;
        req_b = '0; code_b = '0; rsp_ready_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic next_grant(output logic [3:0] g);
        int unsigned n = 0;
        while (gnt_a != 4'b0000 && n < 50) begin @(posedge clk); #1; n++; end
        while (gnt_a == 4'b0000 && n < 100) begin @(posedge clk); #1; n++; end
        g = gnt_a;
    endtask

    task automatic wait_idle(input string nm);
        int unsigned n = 0;
        while (busy_a && n < 50) begin @(posedge clk); #1; n++; end
        chk(nm, 32'(busy_a), 32'd0);
    endtask

    // Scoreboard consumer: every handshake pops one expected response.
    always @(negedge clk) begin
        if (!rst && rsp_valid_a && rsp_ready_a) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got id %0d data %b expected no response",
                         rsp_id_a, rsp_data_a);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_id", 32'(rsp_id_a), 32'(mon_e.id));
                chk("sb_data", 32'(rsp_data_a), 32'(mon_e.data));
            end
        end
    end

    initial begin
        logic [3:0] g;

        // Single op, SETTLE=1
        tbl.push_back(mk(1'b1, 4'b0001, 16'h0009, 1'b1, 1'b1, 2'd0, 5'b01001, 4'b0001, 1'b1, 4'b1001, 1'b0, 2'd0, 5'b00000));
        tbl.push_back(mk(1'b0, 4'b0000, 16'h0009, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0001, 1'b1, 4'b1001, 1'b1, 2'd0, 5'b01001));
        tbl.push_back(mk(1'b0, 4'b0000, 16'h0009, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 5'b01001));
        // Round-robin with all four requesting
        tbl.push_back(mk(1'b1, 4'b1111, 16'hFC29, 1'b1, 1'b1, 2'd0, 5'b01001, 4'b0001, 1'b1, 4'b1001, 1'b0, 2'd0, 5'b00000));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0001, 1'b1, 4'b1001, 1'b1, 2'd0, 5'b01001));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 5'b01001));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b1, 2'd1, 5'b00010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd1, 5'b01001));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 5'b00010));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 5'b00010));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b1, 2'd2, 5'b10010, 4'b0100, 1'b1, 4'b1100, 1'b0, 2'd2, 5'b00010));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0100, 1'b1, 4'b1100, 1'b1, 2'd2, 5'b10010));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 5'b10010));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b1, 2'd3, 5'b10101, 4'b1000, 1'b1, 4'b1111, 1'b0, 2'd3, 5'b10010));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b1000, 1'b1, 4'b1111, 1'b1, 2'd3, 5'b10101));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 5'b10101));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b1, 2'd0, 5'b01001, 4'b0001, 1'b1, 4'b1001, 1'b0, 2'd0, 5'b10101));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0001, 1'b1, 4'b1001, 1'b1, 2'd0, 5'b01001));
        tbl.push_back(mk(1'b0, 4'b1111, 16'hFC29, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 5'b01001));

        // Reset state on both instances
        @(posedge clk); #1;
        chk("rst_gnt", 32'(gnt_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_dec", 32'(dec_abcd_a), 32'd0);
        chk("rst_valid", 32'(rsp_valid_a), 32'd0);
        chk("rst_id", 32'(rsp_id_a), 32'd0);
        chk("rst_data", 32'(rsp_data_a), 32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd0);
        chk("rst_b_valid", 32'(rsp_valid_b), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            req_a = tbl[i].req;
            code_a = tbl[i].code;
            rsp_ready_a = tbl[i].rdy;
            if (tbl[i].push) sb_q.push_back('{id: tbl[i].sb_id, data: tbl[i].sb_data});
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt_a), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_dec", i), 32'(dec_abcd_a), 32'(tbl[i].dec));
            chk($sformatf("tbl%0d_valid", i), 32'(rsp_valid_a), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_id", i), 32'(rsp_id_a), 32'(tbl[i].id));
            chk($sformatf("tbl%0d_data", i), 32'(rsp_data_a), 32'(tbl[i].data));
        end

        // Backpressure: requester 2 with rsp_ready low for five valid cycles
        req_a = 4'b0100;
        code_a = 16'h0600;
        rsp_ready_a = 1'b0;
        sb_q.push_back('{id: 2'd2, data: 5'b10110});
        @(posedge clk); #1;
        req_a = 4'b0000;
        chk("bp_gnt", 32'(gnt_a), 32'b0100);
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), 32'(rsp_valid_a), 32'd1);
            chk($sformatf("bp%0d_data", k), 32'(rsp_data_a), 32'b10110);
            chk($sformatf("bp%0d_gnt", k), 32'(gnt_a), 32'b0100);
            chk($sformatf("bp%0d_dec", k), 32'(dec_abcd_a), 32'b0110);
            @(posedge clk);
        end
        #1 rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        chk("bp_done_valid", 32'(rsp_valid_a), 32'd0);
        chk("bp_done_gnt", 32'(gnt_a), 32'd0);
        chk("bp_done_dec", 32'(dec_abcd_a), 32'd0);
        chk("bp_done_data", 32'(rsp_data_a), 32'b10110);

        // Reset asserted while DRIVE is in progress
        req_a = 4'b0001;
        code_a = 16'h000C;
        @(posedge clk); #1;
        chk("mid_busy", 32'(busy_a), 32'd1);
        #1 rst = 1'b1;
        req_a = 4'b0000;
        #1;
        chk("mid_rst_gnt", 32'(gnt_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_dec", 32'(dec_abcd_a), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid_a), 32'd0);
        chk("mid_rst_data", 32'(rsp_data_a), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("mid_rst_hold_valid", 32'(rsp_valid_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_a = 4'b1001;
        code_a = 16'hF00C;
        sb_q.push_back('{id: 2'd0, data: 5'b10010});
        sb_q.push_back('{id: 2'd3, data: 5'b10101});
        @(posedge clk); #1;
        chk("post_rst_gnt", 32'(gnt_a), 32'b0001);
        next_grant(g);
        chk("post_rst_next", 32'(g), 32'b1000);
        req_a = 4'b0000;
        wait_idle("post_rst_idle");

        // Fairness: 2 holds request, 1 arrives during 2's op
        code_a = 16'h0620;
        sb_q.push_back('{id: 2'd2, data: 5'b10110});
        req_a = 4'b0100;
        next_grant(g);
        chk("fair_first", 32'(g), 32'b0100);
        req_a = 4'b0110;
        sb_q.push_back('{id: 2'd1, data: 5'b00010});
        sb_q.push_back('{id: 2'd2, data: 5'b10110});
        next_grant(g);
        chk("fair_second", 32'(g), 32'b0010);
        req_a = 4'b0100;
        next_grant(g);
        chk("fair_third", 32'(g), 32'b0100);
        req_a = 4'b0000;
        wait_idle("fair_idle");

        // SETTLE=4 instance: code and req change after grant must not leak in
        req_b = 4'b1000;
        code_b = 16'hC000;
        @(posedge clk); #1;
        chk("s4_gnt", 32'(gnt_b), 32'b1000);
        chk("s4_dec0", 32'(dec_abcd_b), 32'b1100);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                code_b = 16'h3333;
                req_b = 4'b0000;
            end
            chk($sformatf("s4_dec%0d", k), 32'(dec_abcd_b), 32'b1100);
            chk($sformatf("s4_valid%0d", k), 32'(rsp_valid_b), 32'd0);
        end
        @(posedge clk); #1;
        chk("s4_valid", 32'(rsp_valid_b), 32'd1);
        chk("s4_id", 32'(rsp_id_b), 32'd3);
        chk("s4_data", 32'(rsp_data_b), 32'b10010);
        chk("s4_dec4", 32'(dec_abcd_b), 32'b1100);
        @(posedge clk); #1;
        chk("s4_done_valid", 32'(rsp_valid_b), 32'd0);
        chk("s4_done_gnt", 32'(gnt_b), 32'd0);
        chk("s4_done_data", 32'(rsp_data_b), 32'b10010);
        @(posedge clk); #1;
        chk("s4_no_regrant", 32'(busy_b), 32'd0);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
